lut_reverse_search: RTL and testbench
=====================================

Name: lut_reverse_search

Overview:
- Sequential reverse lookup for the key->address lookup table: given an 8-bit target value, scans keys and returns the first key whose table entry equals it, plus the total match count.
- Sits beside the combinational lookup table. Drives the table's key input and reads its 8-bit output on the same cycle.
- Used by the debug/loader path to recover a constant index (keys 0-15) or a branch label index (keys 16-31) from an address.

Parameters:
- KEY_W, 5, key width; table depth is 2**KEY_W = 32.
- DATA_W, 8, table entry width.
- HALF, 16, first branch key; constants occupy 0..HALF-1 and branches occupy HALF..31.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- target  in  DATA_W  value to search for; latched on the accepted start.
- range_sel  in  2  search range, latched on start: 0 = keys 0-31, 1 = keys 0-15, 2 = keys 16-31, 3 = reserved.
- lut_key  out  KEY_W  key driven to the lookup table.
- lut_data  in  DATA_W  table output for lut_key (combinational, same cycle).
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle completion pulse.
- found  out  1  at least one match in range.
- key_out  out  KEY_W  lowest matching key; 0 if none.
- match_count  out  KEY_W+1  number of matching keys in range, 0..32.

Behaviour:
- Reset (async assert, sync release): state=IDLE; lut_key=0, busy=0, done=0, found=0, key_out=0, match_count=0; target_q=0.
- FSM states: IDLE, SCAN, DONE. All outputs are registered.
- IDLE, start=1, range_sel 0/1/2:
  - latch target_q and bounds lo/hi (0/31, 0/15, 16/31).
  - lut_key<=lo; clear found, key_out, match_count.
  - go to SCAN.
- IDLE, start=1, range_sel=3: clear results and go straight to DONE; no scan, found=0, count=0.
- SCAN, every cycle:
  - if lut_data==target_q: match_count++; if found==0 then found<=1 and key_out<=lut_key. The first match wins.
  - if lut_key==hi, go to DONE; otherwise lut_key<=lut_key+1.
  - Termination is by equality, so lut_key never wraps 31->0.
- DONE: done=1 for exactly one cycle, then IDLE. On entering IDLE, lut_key returns to 0.
- Latency: start accepted at edge E0; scan covers N=hi-lo+1 cycles; done is high during cycle N+1 after E0.
  - Full range: done in cycle 33. Half range: done in cycle 17. Reserved range: done in cycle 1.
- Results (found, key_out, match_count) hold from the done cycle until the next accepted start.
- start while busy is ignored and has no effect on the latched target or range. start high in the DONE cycle is also ignored; start must be re-presented in IDLE.
- target/range_sel changes after acceptance have no effect.
- reset_n low mid-scan returns everything immediately to reset values; no done pulse is issued.
- match_count never overflows: max 32 fits in 6 bits.

Test Plan:
- Reset, then start target=8'hA8 range_sel=0 with the production table -> busy for 33 cycles, done pulse in cycle 33, found=1, key_out=8, match_count=1.
- target=8'd4 range_sel=2 -> done in cycle 17, found=1, key_out=17, count=1. Then same target with range_sel=1 -> found=0, key_out=0, count=0.
- target=8'h00 range_sel=0 -> found=1, key_out=31 (default entry), count=1. Check lut_key visits 0..31 in order, then returns to 0.
- Bench table model returning 8'h20 for every key, range_sel=0 -> found=1, key_out=0, match_count=32. range_sel=3 -> done in cycle 1, found=0, count=0.
- Assert start again at scan cycle 5 with target=8'hFE -> ignored; the original result is returned. Start in the DONE cycle -> ignored.
- Pull reset_n low at scan cycle 10 -> all outputs go to 0 asynchronously, no done pulse. After release, a fresh search for 8'hFE range_sel=1 -> key_out=15.

Source files
------------

// File: rtl/lut_reverse_search.sv
// Sequential reverse lookup for the key->address table: sweeps a key range,
// compares each table entry with a latched target, and reports the first
// matching key and the total number of matches.
module lut_reverse_search #(
  parameter int unsigned KEY_W  = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned HALF   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  input  logic [1:0]        range_sel,
  output logic [KEY_W-1:0]  lut_key,
  input  logic [DATA_W-1:0] lut_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [KEY_W-1:0]  key_out,
  output logic [KEY_W:0]    match_count
);

  localparam logic [KEY_W-1:0] KeyMax   = {KEY_W{1'b1}};
  localparam logic [KEY_W-1:0] HalfKey  = KEY_W'(HALF);
  localparam logic [KEY_W-1:0] HalfLast = KEY_W'(HALF - 1);
  localparam logic [KEY_W-1:0] KeyOne   = KEY_W'(1);
  localparam logic [KEY_W:0]   CountOne = (KEY_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  target_q;
  logic [KEY_W-1:0]   hi_q;

  logic [KEY_W-1:0]   lo_sel;
  logic [KEY_W-1:0]   hi_sel;
  logic               range_ok;

  // Decode the requested range into inclusive key bounds; code 3 is reserved.
  always_comb begin
    lo_sel   = '0;
    hi_sel   = KeyMax;
    range_ok = 1'b1;
    case (range_sel)
      2'd0: ;
      2'd1: hi_sel = HalfLast;
      2'd2: lo_sel = HalfKey;
      default: range_ok = 1'b0;
    endcase
  end

  // Search FSM; every output is a register so the table sees a clean key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      target_q    <= '0;
      hi_q        <= '0;
      lut_key     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      key_out     <= '0;
      match_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          lut_key <= '0;
          if (start) begin
            found       <= 1'b0;
            key_out     <= '0;
            match_count <= '0;
            busy        <= 1'b1;
            if (range_ok) begin
              target_q <= target;
              hi_q     <= hi_sel;
              lut_key  <= lo_sel;
              state_q  <= StScan;
            end else begin
              // Reserved range: report an empty result without scanning.
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StScan: begin
          if (lut_data == target_q) begin
            match_count <= match_count + CountOne;
            if (!found) begin
              found   <= 1'b1;
              key_out <= lut_key;
            end
          end
          // Stop on equality with the upper bound so the key never wraps.
          if (lut_key == hi_q) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            lut_key <= lut_key + KeyOne;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          lut_key <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_reverse_search.sv
// Self-checking bench for lut_reverse_search with a scoreboard of expected
// search results computed from an independent table model.
module tb_lut_reverse_search;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] target;
  logic [1:0] range_sel;
  logic [4:0] lut_key;
  logic [7:0] lut_data;
  logic       busy;
  logic       done;
  logic       found;
  logic [4:0] key_out;
  logic [5:0] match_count;

  logic       all20;
  int         n_cmp;
  int         n_bad;
  logic [4:0] keys_seen [0:127];

  typedef struct packed {
    logic       found;
    logic [4:0] key;
    logic [5:0] count;
    logic [7:0] lat;
  } exp_t;

  typedef struct packed {
    logic       found;
    logic [4:0] key;
    logic [5:0] count;
    logic [7:0] lat;
    logic [7:0] busy_cycles;
    logic       timeout;
    logic [11:0] hold;
    logic       after_busy;
    logic       after_done;
    logic [4:0] after_key;
  } obs_t;

  exp_t exp_q [$];

  lut_reverse_search #(
    .KEY_W  (5),
    .DATA_W (8),
    .HALF   (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .target      (target),
    .range_sel   (range_sel),
    .lut_key     (lut_key),
    .lut_data    (lut_data),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .key_out     (key_out),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Production table stand-in: constants A0.. with FE at 15, branches k-13, default 00 at 31.
  function automatic logic [7:0] entry(input logic [4:0] k, input logic use20);
    if (use20) return 8'h20;
    if (k == 5'd15) return 8'hFE;
    if (k < 5'd16) return 8'hA0 + 8'(k);
    if (k == 5'd31) return 8'h00;
    return 8'(k) - 8'd13;
  endfunction

  assign lut_data = entry(lut_key, all20);

  function automatic exp_t model(input logic [7:0] tgt, input logic [1:0] rng,
                                 input logic use20);
    exp_t e;
    int lo;
    int hi;
    e = '0;
    lo = (rng == 2'd2) ? 16 : 0;
    hi = (rng == 2'd1) ? 15 : 31;
    if (rng == 2'd3) begin
      e.lat = 8'd1;
      return e;
    end
    for (int k = lo; k <= hi; k++) begin
      if (entry(5'(k), use20) == tgt) begin
        if (!e.found) begin
          e.found = 1'b1;
          e.key   = 5'(k);
        end
        e.count = e.count + 6'd1;
      end
    end
    e.lat = 8'(hi - lo + 2);
    return e;
  endfunction

  // Issue one search, push its expectation, and observe it until done.
  task automatic run_search(input logic [7:0] tgt, input logic [1:0] rng, input int inj_cyc,
                            input bit inj_done, output obs_t o);
    int cyc;
    exp_q.push_back(model(tgt, rng, all20));
    o = '0;
    @(posedge clk); #1;
    target = tgt; range_sel = rng; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; target = ~tgt; range_sel = rng ^ 2'd1;
    cyc = 1;
    while (1) begin
      keys_seen[cyc] = lut_key;
      if (busy) o.busy_cycles = o.busy_cycles + 8'd1;
      if (done) break;
      if (cyc >= 100) begin
        o.timeout = 1'b1;
        break;
      end
      if (cyc == inj_cyc) begin
        start = 1'b1; target = 8'hFE; range_sel = 2'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    o.lat = 8'(cyc);
    o.found = found; o.key = key_out; o.count = match_count;
    if (inj_done) begin
      start = 1'b1; target = 8'hFE; range_sel = 2'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    o.after_busy = busy; o.after_done = done; o.after_key = lut_key;
    o.hold = {found, key_out, match_count};
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; target = '0; range_sel = '0; all20 = 1'b0;
    #23;
    n_cmp++;
    if ({lut_key, busy, done, found, key_out, match_count} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got key=%0d busy=%b done=%b found=%b key_out=%0d cnt=%0d want all 0",
               lut_key, busy, done, found, key_out, match_count);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_full_range;
    obs_t o;
    exp_t e;
    run_search(8'hA8, 2'd0, 0, 1'b0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.timeout || o.lat !== e.lat) begin
      n_bad++; $display("FAIL full_latency: got %0d want %0d", o.lat, e.lat);
    end
    n_cmp++;
    if (o.busy_cycles !== 8'd33) begin
      n_bad++; $display("FAIL full_busy_cycles: got %0d want 33", o.busy_cycles);
    end
    n_cmp++;
    if ({o.found, o.key, o.count} !== {e.found, e.key, e.count}) begin
      n_bad++;
      $display("FAIL full_result: got f=%b k=%0d c=%0d want f=%b k=%0d c=%0d",
               o.found, o.key, o.count, e.found, e.key, e.count);
    end
    n_cmp++;
    if (o.hold !== {e.found, e.key, e.count} || o.after_busy !== 1'b0 || o.after_done !== 1'b0) begin
      n_bad++;
      $display("FAIL full_hold: got res=%h busy=%b done=%b want res=%h busy=0 done=0",
               o.hold, o.after_busy, o.after_done, {e.found, e.key, e.count});
    end
  endtask

  task automatic test_half_ranges;
    obs_t o;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_search(8'd4, (i == 0) ? 2'd2 : 2'd1, 0, 1'b0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.timeout || o.lat !== e.lat) begin
        n_bad++; $display("FAIL half_latency_%0d: got %0d want %0d", i, o.lat, e.lat);
      end
      n_cmp++;
      if ({o.found, o.key, o.count} !== {e.found, e.key, e.count}) begin
        n_bad++;
        $display("FAIL half_result_%0d: got f=%b k=%0d c=%0d want f=%b k=%0d c=%0d",
                 i, o.found, o.key, o.count, e.found, e.key, e.count);
      end
    end
  endtask

  task automatic test_key_sweep;
    obs_t o;
    exp_t e;
    int bad;
    run_search(8'h00, 2'd0, 0, 1'b0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if ({o.found, o.key, o.count} !== {e.found, e.key, e.count}) begin
      n_bad++;
      $display("FAIL sweep_result: got f=%b k=%0d c=%0d want f=%b k=%0d c=%0d",
               o.found, o.key, o.count, e.found, e.key, e.count);
    end
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      if (keys_seen[c] !== 5'(c - 1)) bad++;
    end
    n_cmp++;
    if (bad != 0 || keys_seen[33] !== 5'd31) begin
      n_bad++;
      $display("FAIL sweep_order: got %0d misplaced keys, done-cycle key=%0d want 0 misplaced, 31",
               bad, keys_seen[33]);
    end
    n_cmp++;
    if (o.after_key !== 5'd0) begin
      n_bad++; $display("FAIL sweep_key_return: got %0d want 0", o.after_key);
    end
  endtask

  task automatic test_all_match;
    obs_t o;
    exp_t e;
    all20 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_search(8'h20, (i == 0) ? 2'd0 : 2'd3, 0, 1'b0, o);
      e = exp_q.pop_front();
      n_cmp++;
      if (o.timeout || o.lat !== e.lat) begin
        n_bad++; $display("FAIL allmatch_latency_%0d: got %0d want %0d", i, o.lat, e.lat);
      end
      n_cmp++;
      if ({o.found, o.key, o.count} !== {e.found, e.key, e.count}) begin
        n_bad++;
        $display("FAIL allmatch_result_%0d: got f=%b k=%0d c=%0d want f=%b k=%0d c=%0d",
                 i, o.found, o.key, o.count, e.found, e.key, e.count);
      end
    end
    all20 = 1'b0;
  endtask

  task automatic test_start_while_busy;
    obs_t o;
    exp_t e;
    run_search(8'hA8, 2'd0, 5, 1'b1, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.timeout || o.lat !== e.lat) begin
      n_bad++; $display("FAIL busy_start_latency: got %0d want %0d", o.lat, e.lat);
    end
    n_cmp++;
    if ({o.found, o.key, o.count} !== {e.found, e.key, e.count}) begin
      n_bad++;
      $display("FAIL busy_start_result: got f=%b k=%0d c=%0d want f=%b k=%0d c=%0d",
               o.found, o.key, o.count, e.found, e.key, e.count);
    end
    n_cmp++;
    if (o.after_busy !== 1'b0 || o.hold !== {e.found, e.key, e.count}) begin
      n_bad++;
      $display("FAIL done_cycle_start: got busy=%b res=%h want busy=0 res=%h",
               o.after_busy, o.hold, {e.found, e.key, e.count});
    end
  endtask

  task automatic test_reset_mid_scan;
    obs_t o;
    exp_t e;
    int pulses;
    @(posedge clk); #1;
    target = 8'hA8; range_sel = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({lut_key, busy, done, found, key_out, match_count} !== 19'd0) begin
      n_bad++;
      $display("FAIL async_reset: got key=%0d busy=%b done=%b found=%b key_out=%0d cnt=%0d want all 0",
               lut_key, busy, done, found, key_out, match_count);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++; $display("FAIL reset_no_done: got %0d busy/done cycles want 0", pulses);
    end
    run_search(8'hFE, 2'd1, 0, 1'b0, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (o.timeout || {o.found, o.key, o.count} !== {e.found, e.key, e.count}) begin
      n_bad++;
      $display("FAIL post_reset_result: got f=%b k=%0d c=%0d want f=%b k=%0d c=%0d",
               o.found, o.key, o.count, e.found, e.key, e.count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_full_range();
    test_half_ranges();
    test_key_sweep();
    test_all_match();
    test_start_while_busy();
    test_reset_mid_scan();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
